sdram_pattern_tester: RTL and testbench

Parametrised SDRAM traffic generator and checker, the successor to the fixed incrementing write/read test. It drives the `sdram_top` FIFO write and read ports in repeated passes: fill `TEST_LEN` words, wait, then read back and compare. The data width, length, settle delay and four data patterns are all selectable. It reports sticky and saturating error information plus a pass counter for LED or debug display.

---
 rtl/sdram_tester_pkg.sv | 27 ++
 rtl/sdram_pattern_tester_if.sv | 12 +
 rtl/pattern_gen.sv | 52 +++++
 rtl/sdram_pattern_tester.sv | 174 +++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_tester_pkg.sv
// Shared types and constants for the SDRAM pattern tester.
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READ   = 3'd3,
    ST_DRAIN  = 3'd4
  } tester_state_t;

  typedef enum logic [1:0] {
    PAT_INC  = 2'd0,
    PAT_INV  = 2'd1,
    PAT_WALK = 2'd2,
    PAT_LFSR = 2'd3
  } pattern_t;

  localparam logic [31:0] LFSR_MASK      = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_BASE = 32'hACE1_0000;

  // One Galois shift: feed back the mask when the bit shifted out is set.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/sdram_pattern_tester_if.sv
// FIFO write/read port pair between the tester and sdram_top.
interface sdram_pattern_tester_if #(
  parameter int DATA_W = 64
) ();
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  modport master (output wr_en, output wr_data, output rd_en, input rd_data);
  modport slave  (input wr_en, input wr_data, input rd_en, output rd_data);
endinterface

// File: rtl/pattern_gen.sv
// Pattern word generator: word index plus LFSR, restartable and advanced once per word.
module pattern_gen
  import sdram_tester_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 24
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              advance,
  input  pattern_t          mode,
  input  logic [31:0]       seed,
  output logic [DATA_W-1:0] word
);

  localparam int REPS = (DATA_W + 31) / 32;
  localparam logic [ADDR_W-1:0] DW_A = ADDR_W'(DATA_W);

  logic [ADDR_W-1:0] idx;
  logic [31:0]       lfsr;
  logic [ADDR_W-1:0] bit_pos;

  assign bit_pos = idx % DW_A;

  // Index and LFSR state: restart wins over advance.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      lfsr <= LFSR_SEED_BASE;
    end else if (restart) begin
      idx  <= '0;
      lfsr <= seed;
    end else if (advance) begin
      idx  <= idx + 1'b1;
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Map the current index/LFSR to a data word for the selected pattern.
  always_comb begin
    word = '0;
    case (mode)
      PAT_INC:  word = DATA_W'(idx);
      PAT_INV:  word = DATA_W'(~idx);
      PAT_WALK: word = DATA_W'(1) << bit_pos;
      PAT_LFSR: word = DATA_W'({REPS{lfsr}});
      default:  word = '0;
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM traffic generator/checker: repeated fill, settle, read-back and compare passes.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | waiting for run && init_done, generators held at 0
// ST_WRITE  | wr_en every cycle for TEST_LEN words
// ST_SETTLE | WAIT_CYC idle cycles, check generator rewound
// ST_READ   | rd_en every cycle for TEST_LEN words
// ST_DRAIN  | final compare, pass_count++, loop or stop
module sdram_pattern_tester
  import sdram_tester_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int unsigned TEST_LEN  = 24'h400000,
  parameter int          ADDR_W    = 24,
  parameter int unsigned WAIT_CYC  = 1024,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                      clk_50m,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [1:0]                pattern_sel,
  input  logic                      sdram_init_done,
  sdram_pattern_tester_if.master    fifo,
  output logic                      busy,
  output logic                      error_flag,
  output logic [ERR_CNT_W-1:0]      err_count,
  output logic [ADDR_W-1:0]         first_err_idx,
  output logic [3:0]                pass_count
);

  logic [1:0]        run_sync;
  logic [1:0]        init_sync;
  logic              run_s;
  logic              init_s;
  tester_state_t     state;
  tester_state_t     state_nxt;
  logic [ADDR_W-1:0] word_cnt;
  logic [31:0]       wait_cnt;
  logic              word_tc;
  logic              wait_tc;
  logic              pass_start;
  logic              pass_done;
  pattern_t          mode_q;
  logic [31:0]       seed;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] chk_word;
  logic              rd_valid;
  logic [ADDR_W-1:0] chk_idx;
  logic              mismatch;

  assign run_s   = run_sync[1];
  assign init_s  = init_sync[1];
  assign word_tc = (word_cnt == '0);
  assign wait_tc = (wait_cnt == '0);

  // Two-flop synchronisers for the asynchronous control inputs.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      run_sync  <= '0;
      init_sync <= '0;
    end else begin
      run_sync  <= {run_sync[0], run};
      init_sync <= {init_sync[0], sdram_init_done};
    end
  end

  // FSM state register.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; losing init_done anywhere in a pass aborts without counting it.
  always_comb begin
    state_nxt = state;
    pass_done = 1'b0;
    case (state)
      ST_IDLE:   if (run_s && init_s) state_nxt = ST_WRITE;
      ST_WRITE:  if (!init_s) state_nxt = ST_IDLE;
                 else if (word_tc) state_nxt = ST_SETTLE;
      ST_SETTLE: if (!init_s) state_nxt = ST_IDLE;
                 else if (wait_tc) state_nxt = ST_READ;
      ST_READ:   if (!init_s) state_nxt = ST_IDLE;
                 else if (word_tc) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!init_s) state_nxt = ST_IDLE;
                 else begin
                   pass_done = 1'b1;
                   state_nxt = run_s ? ST_WRITE : ST_IDLE;
                 end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign pass_start = (state_nxt == ST_WRITE) && (state != ST_WRITE);

  // Terminal-count down-counters for the word phases and the settle gap.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= ADDR_W'(TEST_LEN - 1);
      wait_cnt <= 32'(WAIT_CYC - 1);
    end else begin
      word_cnt <= (state == ST_WRITE || state == ST_READ) ? word_cnt - 1'b1
                                                          : ADDR_W'(TEST_LEN - 1);
      wait_cnt <= (state == ST_SETTLE) ? wait_cnt - 1'b1 : 32'(WAIT_CYC - 1);
    end
  end

  // Pattern selection is frozen for the whole pass.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)          mode_q <= PAT_INC;
    else if (pass_start) mode_q <= pattern_t'(pattern_sel);
  end

  // The writer reloads in DRAIN for the next pass, whose pass_count is one higher.
  assign seed = LFSR_SEED_BASE +
                {28'd0, (state == ST_DRAIN) ? pass_count + 4'd1 : pass_count};

  pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr_gen (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .restart (state == ST_IDLE || state == ST_DRAIN),
    .advance (fifo.wr_en),
    .mode    (mode_q),
    .seed    (seed),
    .word    (wr_word)
  );

  pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_chk_gen (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .restart (state == ST_SETTLE),
    .advance (rd_valid),
    .mode    (mode_q),
    .seed    (seed),
    .word    (chk_word)
  );

  assign fifo.wr_en   = (state == ST_WRITE);
  assign fifo.rd_en   = (state == ST_READ);
  assign fifo.wr_data = fifo.wr_en ? wr_word : '0;
  assign busy         = (state != ST_IDLE);
  assign mismatch     = rd_valid && (fifo.rd_data != chk_word);

  // Read data lags rd_en by one cycle; track which word it belongs to.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      chk_idx  <= '0;
    end else begin
      rd_valid <= fifo.rd_en;
      if (state == ST_SETTLE) chk_idx <= '0;
      else if (rd_valid)      chk_idx <= chk_idx + 1'b1;
    end
  end

  // Sticky error flag, saturating count, first failing index and pass counter.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      error_flag    <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      pass_count    <= '0;
    end else begin
      if (mismatch) begin
        error_flag <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!error_flag)     first_err_idx <= chk_idx;
      end
      pass_count <= pass_count + {3'd0, pass_done};
    end
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: FIFO-plus-memory model with read corruption and a pattern reference.
module tb_sdram_pattern_tester;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TL = 16;
  localparam int WC = 4;
  localparam int EW = 2;

  logic          clk_50m = 1'b0;
  logic          rst_n;
  logic          run;
  logic [1:0]    pattern_sel;
  logic          sdram_init_done;
  logic          busy;
  logic          error_flag;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_idx;
  logic [3:0]    pass_count;

  sdram_pattern_tester_if #(.DATA_W(DW)) fifo ();

  sdram_pattern_tester #(
    .DATA_W(DW), .TEST_LEN(TL), .ADDR_W(AW), .WAIT_CYC(WC), .ERR_CNT_W(EW)
  ) dut (
    .clk_50m         (clk_50m),
    .rst_n           (rst_n),
    .run             (run),
    .pattern_sel     (pattern_sel),
    .sdram_init_done (sdram_init_done),
    .fifo            (fifo),
    .busy            (busy),
    .error_flag      (error_flag),
    .err_count       (err_count),
    .first_err_idx   (first_err_idx),
    .pass_count      (pass_count)
  );

  always #5 clk_50m = ~clk_50m;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [TL];
  logic          corrupt [TL];
  logic          invert_all;
  int            wptr = 0;
  int            rptr = 0;
  int            wr_idx = 0;
  int            rd_idx = 0;
  int            model_passes = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected word i of a pass, straight from the pattern definitions.
  function automatic logic [DW-1:0] ref_pat(input int mode, input int i, input int pass);
    logic [31:0]   l;
    logic [AW-1:0] ia;
    ia = AW'(i);
    case (mode)
      0: return DW'(ia);
      1: return DW'(~ia);
      2: return DW'(1) << (i % DW);
      default: begin
        l = 32'hACE1_0000 + 32'(pass % 16);
        for (int k = 0; k < i; k++) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        return DW'(l);
      end
    endcase
  endfunction

  // SDRAM model: writes land in memory, reads return one cycle later, optionally corrupted.
  always @(posedge clk_50m) begin
    if (!busy) begin
      wptr <= 0;
      rptr <= 0;
    end else begin
      if (fifo.wr_en) begin
        mem[wptr] <= fifo.wr_data;
        wptr      <= (wptr + 1) % TL;
      end
      if (fifo.rd_en) rptr <= (rptr + 1) % TL;
    end
    fifo.rd_data <= invert_all ? ~mem[rptr] : (mem[rptr] ^ (corrupt[rptr] ? DW'(1) : DW'(0)));
  end

  // Write-data and port exclusivity monitor; counts completed passes.
  initial begin
    forever begin
      @(negedge clk_50m);
      if (!rst_n) begin
        wr_idx = 0; rd_idx = 0; model_passes = 0;
      end else begin
        if (fifo.wr_en || fifo.rd_en)
          check_eq("wr_rd_exclusive", 32'(fifo.wr_en & fifo.rd_en), 32'd0);
        if (fifo.wr_en) begin
          check_eq("wr_data", 32'(fifo.wr_data), 32'(ref_pat(int'(pattern_sel), wr_idx, model_passes)));
          wr_idx = (wr_idx + 1) % TL;
        end
        if (fifo.rd_en) begin
          rd_idx++;
          if (rd_idx == TL) begin
            rd_idx = 0;
            model_passes++;
          end
        end
        if (!busy) begin
          wr_idx = 0; rd_idx = 0;
        end
      end
    end
  end

  task automatic wait_sig(input string tag, input int which, input int budget);
    int n;
    bit hit;
    n = 0; hit = 1'b0;
    while (!hit && n < budget) begin
      case (which)
        0:       hit = fifo.wr_en;
        1:       hit = fifo.rd_en;
        default: hit = !busy;
      endcase
      if (!hit) begin
        @(negedge clk_50m);
        n++;
      end
    end
    if (!hit) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_one_pass(input string tag);
    run = 1'b1;
    wait_sig({tag, "_wr"}, 0, 20);
    run = 1'b0;
    wait_sig({tag, "_done"}, 2, 100);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_wr_en"}, 32'(fifo.wr_en), 32'd0);
    check_eq({tag, "_rd_en"}, 32'(fifo.rd_en), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(fifo.wr_data), 32'd0);
    check_eq({tag, "_err_flag"}, 32'(error_flag), 32'd0);
    check_eq({tag, "_err_count"}, 32'(err_count), 32'd0);
    check_eq({tag, "_first_idx"}, 32'(first_err_idx), 32'd0);
    check_eq({tag, "_pass_count"}, 32'(pass_count), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwr, nrd, gap, first_rd, n, ncor, first_bad, mode;

    rst_n = 1'b0; run = 1'b0; sdram_init_done = 1'b0; pattern_sel = 2'd0; invert_all = 1'b0;
    for (int i = 0; i < TL; i++) begin
      corrupt[i] = 1'b0;
      mem[i]     = '0;
    end
    repeat (3) @(negedge clk_50m);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk_50m);

    // Mode 0 pass with timing checks; run drops mid-READ.
    pattern_sel = 2'd0; sdram_init_done = 1'b1; run = 1'b1;
    lat = 0;
    while (!fifo.wr_en && lat < 20) begin
      @(negedge clk_50m);
      lat++;
    end
    check_eq("first_wr_latency", 32'(lat), 32'd3);
    nwr = 0; nrd = 0; gap = 0; first_rd = -1;
    for (int c = 0; c <= 38; c++) begin
      if (c > 0) @(negedge clk_50m);
      if (c == 25) run = 1'b0;
      if (fifo.wr_en) nwr++;
      if (fifo.rd_en) begin
        if (nrd == 0) first_rd = c;
        nrd++;
      end
      if (!fifo.wr_en && !fifo.rd_en && nwr == TL && nrd == 0) gap++;
    end
    check_eq("write_count", 32'(nwr), 32'(TL));
    check_eq("read_count", 32'(nrd), 32'(TL));
    check_eq("settle_gap", 32'(gap), 32'(WC));
    check_eq("first_rd_cycle", 32'(first_rd), 32'd20);
    check_eq("pass1_count", 32'(pass_count), 32'd1);
    check_eq("pass1_err_flag", 32'(error_flag), 32'd0);
    check_eq("run_drop_idle", 32'(busy), 32'd0);

    // Walking one at 8 bits wraps every 8 words.
    pattern_sel = 2'd2;
    run_one_pass("walk");
    check_eq("walk_err_flag", 32'(error_flag), 32'd0);
    check_eq("walk_pass_count", 32'(pass_count), 32'd2);

    // Corrupt word 5: error visible 2 cycles after its rd_en.
    pattern_sel = 2'($urandom_range(0, 3));
    corrupt[5] = 1'b1;
    run = 1'b1;
    nrd = 0; n = 0;
    while (nrd < 6 && n < 200) begin
      @(negedge clk_50m);
      n++;
      if (fifo.wr_en) run = 1'b0;
      if (fifo.rd_en) nrd++;
    end
    check_eq("rd5_seen", 32'(nrd), 32'd6);
    @(negedge clk_50m);
    check_eq("err_flag_k_plus_1", 32'(error_flag), 32'd0);
    @(negedge clk_50m);
    check_eq("err_flag_k_plus_2", 32'(error_flag), 32'd1);
    wait_sig("c5_done", 2, 100);
    check_eq("c5_err_count", 32'(err_count), 32'd1);
    check_eq("c5_first_idx", 32'(first_err_idx), 32'd5);
    check_eq("c5_pass_count", 32'(pass_count), 32'd3);

    corrupt[5] = 1'b0; corrupt[9] = 1'b1;
    run_one_pass("c9");
    check_eq("c9_err_count", 32'(err_count), 32'd2);
    check_eq("c9_first_idx", 32'(first_err_idx), 32'd5);
    check_eq("c9_pass_count", 32'(pass_count), 32'd4);
    corrupt[9] = 1'b0;

    // All words inverted: counter saturates.
    invert_all = 1'b1;
    pattern_sel = 2'($urandom_range(0, 3));
    run_one_pass("inv");
    check_eq("sat_err_count", 32'(err_count), 32'd3);
    check_eq("sat_err_flag", 32'(error_flag), 32'd1);
    check_eq("sat_first_idx", 32'(first_err_idx), 32'd5);
    check_eq("sat_pass_count", 32'(pass_count), 32'd5);
    invert_all = 1'b0;

    // init_done lost mid-WRITE aborts without counting; error state kept.
    pattern_sel = 2'($urandom_range(0, 3));
    run = 1'b1;
    wait_sig("abort_wr", 0, 20);
    repeat ($urandom_range(2, 8)) @(negedge clk_50m);
    sdram_init_done = 1'b0;
    wait_sig("abort_idle", 2, 10);
    check_eq("abort_pass_count", 32'(pass_count), 32'd5);
    check_eq("abort_err_count", 32'(err_count), 32'd3);
    check_eq("abort_wr_en", 32'(fifo.wr_en), 32'd0);

    // Reset pulsed mid-READ clears everything without waiting for a clock.
    sdram_init_done = 1'b1;
    wait_sig("rst_rd", 1, 60);
    repeat ($urandom_range(1, 10)) @(negedge clk_50m);
    #2 rst_n = 1'b0;
    #1 check_cleared("async_rst");
    run = 1'b0;
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);

    // Random corruption sets and patterns from a fresh reset each time.
    for (int it = 0; it < 3; it++) begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk_50m);
      rst_n = 1'b1;
      @(negedge clk_50m);
      mode = int'($urandom_range(0, 3));
      ncor = 0; first_bad = -1;
      for (int i = 0; i < TL; i++) begin
        corrupt[i] = ($urandom_range(0, 3) == 0);
        if (corrupt[i]) begin
          ncor++;
          if (first_bad < 0) first_bad = i;
        end
      end
      pattern_sel = 2'(mode);
      run_one_pass("rand");
      check_eq("rand_err_count", 32'(err_count), 32'((ncor > 3) ? 3 : ncor));
      check_eq("rand_err_flag", 32'(error_flag), 32'(ncor > 0));
      check_eq("rand_first_idx", 32'(first_err_idx), 32'((first_bad < 0) ? 0 : first_bad));
      check_eq("rand_pass_count", 32'(pass_count), 32'd1);
      for (int i = 0; i < TL; i++) corrupt[i] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
